// File: rtl/argmax_stream_if.sv
// Valid/ready bundle for argmax_stream: element stream in, (index, value) result out.
interface argmax_stream_if #(
  parameter int unsigned T = 16,
  parameter int unsigned M = 4
);
  localparam int unsigned IDXW = (M > 1) ? $clog2(M) : 1;

  logic                   s_valid;
  logic                   s_ready;
  logic signed [T-1:0]    data_in;
  logic                   m_valid;
  logic                   m_ready;
  logic [IDXW-1:0]        max_idx;
  logic signed [T-1:0]    max_val;

  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, max_idx, max_val
  );

  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, max_idx, max_val
  );
endinterface

// File: rtl/argmax_stream.sv
// Groups every M accepted signed words into a vector and emits the index/value of its maximum.
module argmax_stream #(
  parameter int unsigned T = 16,
  parameter int unsigned M = 4
) (
  input  logic            clk,
  input  logic            reset,
  argmax_stream_if.slave  bus
);
  localparam int unsigned     IDXW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(M - 1);

  logic [IDXW-1:0]     cnt_q, cnt_d;
  logic [IDXW-1:0]     run_idx_q, run_idx_d;
  logic signed [T-1:0] run_val_q, run_val_d;
  logic                m_valid_q, m_valid_d;
  logic [IDXW-1:0]     max_idx_q, max_idx_d;
  logic signed [T-1:0] max_val_q, max_val_d;

  logic s_ready_c;
  logic is_last_c;
  logic accept_c;
  logic pop_c;
  logic take_new_c;

  // Only the last element must wait for the output register to free up.
  assign is_last_c  = (cnt_q == LAST);
  assign s_ready_c  = !is_last_c || !m_valid_q || bus.m_ready;
  assign accept_c   = bus.s_valid && s_ready_c;
  assign pop_c      = m_valid_q && bus.m_ready;
  // Strict compare keeps the earliest index on ties; element 0 always seeds.
  assign take_new_c = (cnt_q == '0) || (bus.data_in > run_val_q);

  always_comb begin
    cnt_d     = cnt_q;
    run_idx_d = run_idx_q;
    run_val_d = run_val_q;
    m_valid_d = m_valid_q;
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;

    if (pop_c) begin
      m_valid_d = 1'b0;
    end

    if (accept_c) begin
      if (is_last_c) begin
        m_valid_d = 1'b1;
        cnt_d     = '0;
        if (take_new_c) begin
          max_idx_d = cnt_q;
          max_val_d = bus.data_in;
        end else begin
          max_idx_d = run_idx_q;
          max_val_d = run_val_q;
        end
      end else begin
        cnt_d = cnt_q + IDXW'(1);
        if (take_new_c) begin
          run_idx_d = cnt_q;
          run_val_d = bus.data_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      run_idx_q <= '0;
      run_val_q <= '0;
      m_valid_q <= 1'b0;
      max_idx_q <= '0;
      max_val_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      run_idx_q <= run_idx_d;
      run_val_q <= run_val_d;
      m_valid_q <= m_valid_d;
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_q;
  assign bus.max_idx = max_idx_q;
  assign bus.max_val = max_val_q;
endmodule

// File: tb/tb_argmax_stream.sv
// Self-checking bench for argmax_stream (M=4 main instance plus an M=1 instance).
module tb_argmax_stream;
  localparam int unsigned T = 16;
  localparam int unsigned M = 4;
  localparam int unsigned NWORDS = 10000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  argmax_stream_if #(.T(T), .M(M)) bus  ();
  argmax_stream_if #(.T(T), .M(1)) bus1 ();

  argmax_stream #(.T(T), .M(M)) dut  (.clk(clk), .reset(reset), .bus(bus));
  argmax_stream #(.T(T), .M(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Present one word on the M=4 instance and hold it until accepted (bounded).
  task automatic push(input logic signed [T-1:0] w);
    bit done;
    done = 1'b0;
    bus.s_valid = 1'b1;
    bus.data_in = w;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL push_timeout: word %0d not accepted within 50 cycles", w);
    end
    bus.s_valid = 1'b0;
    bus.data_in = 'x;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.s_valid = 1'b0;  bus.m_ready = 1'b0;  bus.data_in = 'x;
    bus1.s_valid = 1'b0; bus1.m_ready = 1'b0; bus1.data_in = 'x;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
    checks++; if (bus.max_idx !== 2'd0) begin errors++; $display("FAIL reset_max_idx: got %0d expected 0", bus.max_idx); end
    checks++; if (bus.max_val !== 16'sd0) begin errors++; $display("FAIL reset_max_val: got %h expected 0000", bus.max_val); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", bus.s_ready); end
    checks++; if (bus1.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m1_m_valid: got %b expected 0", bus1.m_valid); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bus.m_ready = 1'b1;
    push(16'sd3); push(-16'sd2); push(16'sd7);
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", bus.m_valid); end
    push(16'sd1);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.max_idx !== 2'd2 || bus.max_val !== 16'sd7) begin
      errors++;
      $display("FAIL basic_result: got v=%b idx=%0d val=%h expected v=1 idx=2 val=0007", bus.m_valid, bus.max_idx, bus.max_val);
    end
    @(posedge clk); #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_single_result: got %b expected 0", bus.m_valid); end
  endtask

  task automatic test_ties();
    logic signed [T-1:0] vecs [3][4];
    logic [1:0]          exp_idx [3];
    logic signed [T-1:0] exp_val [3];
    vecs = '{'{16'sd5, 16'sd5, -16'sd1, 16'sd5},
             '{-16'sd8, -16'sd3, -16'sd3, -16'sd100},
             '{16'h8000, 16'h8000, 16'h8000, 16'h8000}};
    exp_idx = '{2'd0, 2'd1, 2'd0};
    exp_val = '{16'h0005, 16'hFFFD, 16'h8000};
    bus.m_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int e = 0; e < 4; e++) push(vecs[v][e]);
      checks++;
      if (bus.m_valid !== 1'b1 || bus.max_idx !== exp_idx[v] || bus.max_val !== exp_val[v]) begin
        errors++;
        $display("FAIL ties_vec%0d: got v=%b idx=%0d val=%h expected v=1 idx=%0d val=%h",
                 v, bus.m_valid, bus.max_idx, bus.max_val, exp_idx[v], exp_val[v]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    bus.m_ready = 1'b0;
    push(16'sd1); push(16'sd2); push(16'sd3); push(16'sd4);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.max_idx !== 2'd3 || bus.max_val !== 16'sd4) begin
      errors++;
      $display("FAIL bp_result_a: got v=%b idx=%0d val=%h expected v=1 idx=3 val=0004", bus.m_valid, bus.max_idx, bus.max_val);
    end
    push(16'sd9); push(16'sd0); push(16'sd0);
    bus.s_valid = 1'b1;
    bus.data_in = 16'sd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || bus.max_idx !== 2'd3 || bus.max_val !== 16'sd4) begin
        errors++;
        $display("FAIL bp_stall_%0d: got rdy=%b v=%b idx=%0d val=%h expected rdy=0 v=1 idx=3 val=0004",
                 k, bus.s_ready, bus.m_valid, bus.max_idx, bus.max_val);
      end
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.s_ready); end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.data_in = 'x;
    bus.m_ready = 1'b0;
    checks++;
    if (bus.m_valid !== 1'b1 || bus.max_idx !== 2'd0 || bus.max_val !== 16'sd9) begin
      errors++;
      $display("FAIL bp_result_b: got v=%b idx=%0d val=%h expected v=1 idx=0 val=0009", bus.m_valid, bus.max_idx, bus.max_val);
    end
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus.m_valid); end
  endtask

  task automatic test_reset_mid();
    bus.m_ready = 1'b1;
    push(16'sd100); push(16'sd200);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.m_valid); end
    push(16'sd1); push(16'sd4); push(16'sd2);
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale_vector: got %b expected 0", bus.m_valid); end
    push(16'sd3);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.max_idx !== 2'd1 || bus.max_val !== 16'sd4) begin
      errors++;
      $display("FAIL rstmid_result: got v=%b idx=%0d val=%h expected v=1 idx=1 val=0004", bus.m_valid, bus.max_idx, bus.max_val);
    end
    @(posedge clk); #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_single: got %b expected 0", bus.m_valid); end
  endtask

  task automatic test_m1();
    bus1.m_ready = 1'b1;
    bus1.s_valid = 1'b1;
    bus1.data_in = -16'sd5;
    @(negedge clk);
    checks++; if (bus1.s_ready !== 1'b1) begin errors++; $display("FAIL m1_ready: got %b expected 1", bus1.s_ready); end
    @(posedge clk); #1;
    bus1.data_in = 16'sd7;
    checks++;
    if (bus1.m_valid !== 1'b1 || bus1.max_idx !== 1'b0 || bus1.max_val !== 16'hFFFB) begin
      errors++;
      $display("FAIL m1_first: got v=%b idx=%0d val=%h expected v=1 idx=0 val=fffb", bus1.m_valid, bus1.max_idx, bus1.max_val);
    end
    @(posedge clk); #1;
    bus1.s_valid = 1'b0;
    bus1.data_in = 'x;
    checks++;
    if (bus1.m_valid !== 1'b1 || bus1.max_idx !== 1'b0 || bus1.max_val !== 16'h0007) begin
      errors++;
      $display("FAIL m1_second: got v=%b idx=%0d val=%h expected v=1 idx=0 val=0007", bus1.m_valid, bus1.max_idx, bus1.max_val);
    end
    @(posedge clk); #1;
    checks++; if (bus1.m_valid !== 1'b0) begin errors++; $display("FAIL m1_drain: got %b expected 0", bus1.m_valid); end
  endtask

  // Reference model: buffer accepted words, take the first-occurring maximum of each full vector.
  task automatic test_random();
    logic signed [T-1:0] buff [M];
    int                  nbuf, sent, n_out, cycles, best;
    bit                  held, exp_ready, pop, acc;
    int                  h_idx;
    logic signed [T-1:0] h_val;
    nbuf = 0; sent = 0; n_out = 0; cycles = 0; held = 1'b0; h_idx = 0; h_val = '0;
    reset = 1'b1;
    bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    while ((sent < int'(NWORDS) || held) && cycles < 60000) begin
      cycles++;
      bus.s_valid = (sent < int'(NWORDS)) && ($urandom_range(3) != 0);
      bus.data_in = bus.s_valid ? T'($urandom()) : 'x;
      bus.m_ready = (sent >= int'(NWORDS)) ? 1'b1 : ($urandom_range(1) == 1);
      @(negedge clk);
      exp_ready = (nbuf != int'(M) - 1) || !held || bus.m_ready;
      checks++;
      if (bus.s_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_s_ready: cycle %0d got %b expected %b", cycles, bus.s_ready, exp_ready);
      end
      checks++;
      if (bus.m_valid !== held) begin
        errors++;
        $display("FAIL rand_m_valid: cycle %0d got %b expected %b", cycles, bus.m_valid, held);
      end
      if (held) begin
        checks++;
        if (bus.max_idx !== 2'(h_idx) || bus.max_val !== h_val) begin
          errors++;
          $display("FAIL rand_result: cycle %0d got idx=%0d val=%h expected idx=%0d val=%h",
                   cycles, bus.max_idx, bus.max_val, h_idx, h_val);
        end
      end
      pop = held && bus.m_ready;
      acc = bus.s_valid && exp_ready;
      if (pop) begin
        held = 1'b0;
        n_out++;
      end
      if (acc) begin
        buff[nbuf] = bus.data_in;
        nbuf++;
        sent++;
        if (nbuf == int'(M)) begin
          best = 0;
          for (int i = 1; i < int'(M); i++) if (buff[i] > buff[best]) best = i;
          held  = 1'b1;
          h_idx = best;
          h_val = buff[best];
          nbuf  = 0;
        end
      end
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.data_in = 'x;
    checks++;
    if (n_out != int'(NWORDS / M) || sent != int'(NWORDS)) begin
      errors++;
      $display("FAIL rand_counts: got %0d results from %0d words expected %0d results from %0d words",
               n_out, sent, NWORDS / M, NWORDS);
    end
    @(negedge clk);
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rand_idle: got %b expected 0", bus.m_valid); end
  endtask

  initial begin
    reset = 1'b1;
    bus.s_valid = 1'b0;  bus.m_ready = 1'b0;  bus.data_in = 'x;
    bus1.s_valid = 1'b0; bus1.m_ready = 1'b0; bus1.data_in = 'x;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_reset_mid();
    test_m1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
